// File: rtl/misere_board_engine_if.sv
// Move handshake between the keyboard/control FSM (master) and the board engine (slave).
// One move is transferred on each clock edge where move_valid and move_ready are both high.
interface misere_board_engine_if #(
  parameter int POS_W = 7
);
  logic             move_valid;
  logic             move_ready;
  logic [POS_W-1:0] move_pos;
  logic [1:0]       move_sym;

  modport master (output move_valid, move_pos, move_sym, input move_ready);
  modport slave  (input move_valid, move_pos, move_sym, output move_ready);
endinterface

// File: rtl/misere_board_engine.sv
// Wild Misere N-in-a-row engine: validates moves, stores the board, and walks only the
// four lines through each newly placed cell to detect a losing K-run or a full-board tie.
module misere_board_engine #(
  parameter int BOARD_N = 3,
  parameter int WIN_K   = 3,
  parameter int POS_W   = 7
) (
  input  logic                 clock,
  input  logic                 resetn,
  input  logic                 new_game,
  misere_board_engine_if.slave mv,
  output logic                 illegal,
  output logic                 result_valid,
  output logic [1:0]           result,
  output logic                 game_over,
  output logic [1:0]           turn,
  output logic [POS_W-1:0]     move_count,
  input  logic [POS_W-1:0]     rd_addr,
  output logic [1:0]           rd_data
);
  localparam int               NC    = BOARD_N * BOARD_N;
  localparam int               IDX_W = $clog2(NC);
  localparam int               RCW   = 5;
  localparam logic [POS_W-1:0] NC_P  = POS_W'(NC);

  typedef enum logic [2:0] {READY, WRITE, SCAN, REPORT, OVER} state_t;
  state_t state, state_nx;

  logic [1:0]            cells [NC];
  logic [IDX_W-1:0]      p_idx;
  logic [1:0]            p_sym;
  logic signed [RCW-1:0] p_r, p_c, cur_r, cur_c;
  logic [1:0]            dir;
  logic                  back;
  logic [3:0]            run, steps;

  // ---------------- accept / legality ----------------
  logic                  accept, in_range, legal;
  logic [POS_W-1:0]      pos_m1;
  logic [1:0]            tgt;
  logic signed [RCW-1:0] acc_r, acc_c;

  always_comb begin
    pos_m1   = mv.move_pos - 1'b1;
    in_range = (mv.move_pos != '0) && (mv.move_pos <= NC_P);
    tgt      = in_range ? cells[pos_m1[IDX_W-1:0]] : 2'b11;
    accept   = mv.move_valid && (state == READY);
    legal    = in_range && (tgt == 2'b00) &&
               ((mv.move_sym == 2'b01) || (mv.move_sym == 2'b10));
    acc_r    = RCW'(int'(pos_m1) / BOARD_N);
    acc_c    = RCW'(int'(pos_m1) % BOARD_N);
  end

  // ---------------- line walk ----------------
  // Direction vectors: row, column, main diagonal, anti-diagonal; back negates.
  int   dr, dc, nxt_r, nxt_c, nidx;
  logic in_b, step_ok, hit, scan_end;

  always_comb begin
    dr = 0;
    dc = 1;
    case (dir)
      2'd0:    begin dr = 0; dc = 1;  end
      2'd1:    begin dr = 1; dc = 0;  end
      2'd2:    begin dr = 1; dc = 1;  end
      default: begin dr = 1; dc = -1; end
    endcase
    if (back) begin
      dr = -dr;
      dc = -dc;
    end
    nxt_r    = int'(cur_r) + dr;
    nxt_c    = int'(cur_c) + dc;
    in_b     = (nxt_r >= 0) && (nxt_r < BOARD_N) && (nxt_c >= 0) && (nxt_c < BOARD_N);
    nidx     = in_b ? (nxt_r * BOARD_N + nxt_c) : 0;
    step_ok  = (state == SCAN) && in_b && (int'(steps) < WIN_K - 1) &&
               (cells[IDX_W'(nidx)] == p_sym);
    hit      = step_ok && (int'(run) + 1 >= WIN_K);
    scan_end = (state == SCAN) && !step_ok && back && (dir == 2'd3);
  end

  // ---------------- FSM ----------------
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn)       state <= READY;
    else if (new_game) state <= READY;
    else               state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      READY:   if (accept && legal) state_nx = WRITE;
      WRITE:   state_nx = SCAN;
      SCAN:    if (hit || scan_end) state_nx = REPORT;
      REPORT:  state_nx = game_over ? OVER : READY;
      OVER:    state_nx = OVER;
      default: state_nx = READY;
    endcase
  end

  assign mv.move_ready = (state == READY);
  assign result_valid  = (state == REPORT);

  // ---------------- datapath ----------------
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < NC; i++) cells[i] <= 2'b00;
      illegal    <= 1'b0;
      result     <= 2'b00;
      game_over  <= 1'b0;
      turn       <= 2'b01;
      move_count <= '0;
      p_idx      <= '0;
      p_sym      <= 2'b00;
      p_r        <= '0;
      p_c        <= '0;
      cur_r      <= '0;
      cur_c      <= '0;
      dir        <= 2'd0;
      back       <= 1'b0;
      run        <= 4'd1;
      steps      <= 4'd0;
    end else if (new_game) begin
      for (int i = 0; i < NC; i++) cells[i] <= 2'b00;
      illegal    <= 1'b0;
      result     <= 2'b00;
      game_over  <= 1'b0;
      turn       <= 2'b01;
      move_count <= '0;
      dir        <= 2'd0;
      back       <= 1'b0;
      run        <= 4'd1;
      steps      <= 4'd0;
    end else begin
      illegal <= 1'b0;
      case (state)
        READY: if (accept) begin
          if (legal) begin
            p_idx <= pos_m1[IDX_W-1:0];
            p_sym <= mv.move_sym;
            p_r   <= acc_r;
            p_c   <= acc_c;
          end else begin
            illegal <= 1'b1;
          end
        end
        WRITE: begin
          cells[p_idx] <= p_sym;
          move_count   <= move_count + 1'b1;
          dir          <= 2'd0;
          back         <= 1'b0;
          run          <= 4'd1;
          steps        <= 4'd0;
          cur_r        <= p_r;
          cur_c        <= p_c;
        end
        SCAN: begin
          if (hit) begin
            // The mover completed the run, so the opponent takes the game.
            result    <= (turn == 2'b01) ? 2'b10 : 2'b01;
            game_over <= 1'b1;
          end else if (step_ok) begin
            cur_r <= RCW'(nxt_r);
            cur_c <= RCW'(nxt_c);
            run   <= run + 4'd1;
            steps <= steps + 4'd1;
          end else if (!back) begin
            back  <= 1'b1;
            steps <= 4'd0;
            cur_r <= p_r;
            cur_c <= p_c;
          end else if (dir != 2'd3) begin
            dir   <= dir + 2'd1;
            back  <= 1'b0;
            steps <= 4'd0;
            run   <= 4'd1;
            cur_r <= p_r;
            cur_c <= p_c;
          end else if (move_count == NC_P) begin
            result    <= 2'b11;
            game_over <= 1'b1;
          end else begin
            result <= 2'b00;
            turn   <= turn ^ 2'b11;
          end
        end
        default: ;
      endcase
    end
  end

  // ---------------- side read port ----------------
  logic             rd_ok;
  logic [POS_W-1:0] rd_m1;

  always_comb begin
    rd_m1   = rd_addr - 1'b1;
    rd_ok   = (rd_addr != '0) && (rd_addr <= NC_P);
    rd_data = rd_ok ? cells[rd_m1[IDX_W-1:0]] : 2'b00;
  end

  logic unused_bits;
  assign unused_bits = ^{pos_m1, rd_m1};
endmodule

// File: tb/tb_misere_board_engine.sv
// Directed bench for misere_board_engine: a 3x3/K=3 instance and a 5x5/K=4 instance.
module tb_misere_board_engine;
  logic       clock = 1'b0;
  logic       resetn = 1'b0;
  logic       ng3 = 1'b0, ng5 = 1'b0;
  logic       ill3, rv3, go3, ill5, rv5, go5;
  logic [1:0] res3, turn3, rdd3, res5, turn5, rdd5;
  logic [6:0] mc3, mc5;
  logic [6:0] rda3 = '0, rda5 = '0;
  int         cmp = 0, errs = 0;

  misere_board_engine_if #(.POS_W(7)) mi3 ();
  misere_board_engine_if #(.POS_W(7)) mi5 ();

  misere_board_engine #(.BOARD_N(3), .WIN_K(3), .POS_W(7)) u3 (
    .clock(clock), .resetn(resetn), .new_game(ng3), .mv(mi3.slave),
    .illegal(ill3), .result_valid(rv3), .result(res3), .game_over(go3),
    .turn(turn3), .move_count(mc3), .rd_addr(rda3), .rd_data(rdd3));

  misere_board_engine #(.BOARD_N(5), .WIN_K(4), .POS_W(7)) u5 (
    .clock(clock), .resetn(resetn), .new_game(ng5), .mv(mi5.slave),
    .illegal(ill5), .result_valid(rv5), .result(res5), .game_over(go5),
    .turn(turn5), .move_count(mc5), .rd_addr(rda5), .rd_data(rdd5));

  initial forever #5 clock = ~clock;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic rdy_of(int w); return (w == 0) ? mi3.move_ready : mi5.move_ready; endfunction
  function automatic logic rv_of(int w);  return (w == 0) ? rv3 : rv5;   endfunction
  function automatic logic ill_of(int w); return (w == 0) ? ill3 : ill5; endfunction
  function automatic logic [1:0] res_of(int w); return (w == 0) ? res3 : res5; endfunction

  task automatic set_in(int w, logic v, int pos, logic [1:0] sym);
    if (w == 0) begin
      mi3.move_valid = v; mi3.move_pos = 7'(pos); mi3.move_sym = sym;
    end else begin
      mi5.move_valid = v; mi5.move_pos = 7'(pos); mi5.move_sym = sym;
    end
  endtask

  task automatic pulse_ng(int w);
    if (w == 0) ng3 = 1'b1; else ng5 = 1'b1;
    @(negedge clock);
    ng3 = 1'b0; ng5 = 1'b0;
  endtask

  // Offer one move, wait for acceptance, then for result_valid or illegal (bounded).
  task automatic do_move(int w, int pos, logic [1:0] sym,
                         output logic rv, output logic ill, output logic [1:0] res);
    int n;
    rv = 1'b0; ill = 1'b0; res = 2'b00;
    set_in(w, 1'b1, pos, sym);
    n = 0;
    while (!rdy_of(w) && n < 50) begin @(negedge clock); n++; end
    @(posedge clock);
    @(negedge clock);
    set_in(w, 1'b0, 0, 2'b00);
    n = 0;
    while (n < 80) begin
      if (rv_of(w))  begin rv = 1'b1; res = res_of(w); break; end
      if (ill_of(w)) begin ill = 1'b1; break; end
      @(negedge clock);
      n++;
    end
  endtask

  task automatic test_reset;
    set_in(0, 1'b0, 0, 2'b00);
    set_in(1, 1'b0, 0, 2'b00);
    resetn = 1'b0;
    repeat (2) @(negedge clock);
    rda3 = 7'd1;
    #1;
    cmp++;
    if ({mi3.move_ready, rv3, ill3, go3, turn3, res3, mc3, rdd3} !== {1'b1, 1'b0, 1'b0, 1'b0, 2'b01, 2'b00, 7'd0, 2'b00}) begin
      errs++;
      $display("FAIL reset3: got rdy=%b rv=%b ill=%b go=%b turn=%b res=%b mc=%0d cell=%b want 1 0 0 0 01 00 0 00",
               mi3.move_ready, rv3, ill3, go3, turn3, res3, mc3, rdd3);
    end
    cmp++;
    if ({mi5.move_ready, rv5, ill5, go5, turn5, res5, mc5} !== {1'b1, 1'b0, 1'b0, 1'b0, 2'b01, 2'b00, 7'd0}) begin
      errs++;
      $display("FAIL reset5: got rdy=%b rv=%b ill=%b go=%b turn=%b res=%b mc=%0d want 1 0 0 0 01 00 0",
               mi5.move_ready, rv5, ill5, go5, turn5, res5, mc5);
    end
    @(negedge clock);
    resetn = 1'b1;
    @(negedge clock);
  endtask

  task automatic test_p2_loss;
    int         pos[4] = '{1, 5, 2, 3};
    logic [1:0] sym[4] = '{2'b01, 2'b10, 2'b01, 2'b01};
    logic [1:0] exp[4] = '{2'b00, 2'b00, 2'b00, 2'b01};
    logic rv, ill; logic [1:0] res;
    for (int i = 0; i < 4; i++) begin
      do_move(0, pos[i], sym[i], rv, ill, res);
      cmp++;
      if ({rv, ill, res} !== {1'b1, 1'b0, exp[i]}) begin
        errs++;
        $display("FAIL p2_loss move%0d: got rv=%b ill=%b res=%b want rv=1 ill=0 res=%b", i, rv, ill, res, exp[i]);
      end
    end
    @(negedge clock);
    cmp++;
    if ({go3, mi3.move_ready, turn3, mc3} !== {1'b1, 1'b0, 2'b10, 7'd4}) begin
      errs++;
      $display("FAIL p2_loss_over: got go=%b rdy=%b turn=%b mc=%0d want 1 0 10 4", go3, mi3.move_ready, turn3, mc3);
    end
    // A move offered in OVER must be ignored.
    set_in(0, 1'b1, 9, 2'b10);
    repeat (5) @(negedge clock);
    rda3 = 7'd9;
    #1;
    cmp++;
    if ({mc3, rdd3, go3, rv3} !== {7'd4, 2'b00, 1'b1, 1'b0}) begin
      errs++;
      $display("FAIL over_ignore: got mc=%0d cell9=%b go=%b rv=%b want 4 00 1 0", mc3, rdd3, go3, rv3);
    end
    set_in(0, 1'b0, 0, 2'b00);
  endtask

  task automatic test_tie;
    logic [1:0] sym[9] = '{2'b01, 2'b10, 2'b01, 2'b01, 2'b10, 2'b10, 2'b10, 2'b01, 2'b01};
    logic rv, ill; logic [1:0] res, exp;
    pulse_ng(0);
    for (int i = 0; i < 9; i++) begin
      exp = (i == 8) ? 2'b11 : 2'b00;
      do_move(0, i + 1, sym[i], rv, ill, res);
      cmp++;
      if ({rv, ill, res} !== {1'b1, 1'b0, exp}) begin
        errs++;
        $display("FAIL tie move%0d: got rv=%b ill=%b res=%b want rv=1 ill=0 res=%b", i, rv, ill, res, exp);
      end
    end
    @(negedge clock);
    cmp++;
    if ({go3, mc3, turn3, res3} !== {1'b1, 7'd9, 2'b01, 2'b11}) begin
      errs++;
      $display("FAIL tie_final: got go=%b mc=%0d turn=%b res=%b want 1 9 01 11", go3, mc3, turn3, res3);
    end
  endtask

  task automatic test_illegal;
    int         pos[4] = '{5, 0, 10, 1};
    logic [1:0] sym[4] = '{2'b10, 2'b01, 2'b01, 2'b11};
    logic rv, ill; logic [1:0] res;
    pulse_ng(0);
    do_move(0, 5, 2'b01, rv, ill, res);
    cmp++;
    if ({rv, ill, res} !== {1'b1, 1'b0, 2'b00}) begin
      errs++;
      $display("FAIL illegal_setup: got rv=%b ill=%b res=%b want 1 0 00", rv, ill, res);
    end
    for (int i = 0; i < 4; i++) begin
      do_move(0, pos[i], sym[i], rv, ill, res);
      cmp++;
      if ({rv, ill} !== {1'b0, 1'b1}) begin
        errs++;
        $display("FAIL illegal%0d: got rv=%b ill=%b want rv=0 ill=1", i, rv, ill);
      end
    end
    @(negedge clock);
    rda3 = 7'd5;
    #1;
    cmp++;
    if ({mc3, turn3, rdd3, mi3.move_ready, ill3} !== {7'd1, 2'b10, 2'b01, 1'b1, 1'b0}) begin
      errs++;
      $display("FAIL illegal_state: got mc=%0d turn=%b cell5=%b rdy=%b ill=%b want 1 10 01 1 0",
               mc3, turn3, rdd3, mi3.move_ready, ill3);
    end
    rda3 = 7'd1;
    #1;
    cmp++;
    if (rdd3 !== 2'b00) begin
      errs++;
      $display("FAIL illegal_cell1: got %b want 00", rdd3);
    end
    rda3 = 7'd10;
    #1;
    cmp++;
    if (rdd3 !== 2'b00) begin
      errs++;
      $display("FAIL rd_oob: got %b want 00", rdd3);
    end
  endtask

  task automatic test_n5_row;
    int         pa[4] = '{7, 9, 10, 8};
    logic [1:0] ea[4] = '{2'b00, 2'b00, 2'b00, 2'b01};
    int         pb[3] = '{4, 5, 6};
    logic rv, ill; logic [1:0] res;
    for (int i = 0; i < 4; i++) begin
      do_move(1, pa[i], 2'b01, rv, ill, res);
      cmp++;
      if ({rv, ill, res} !== {1'b1, 1'b0, ea[i]}) begin
        errs++;
        $display("FAIL n5_row move%0d: got rv=%b ill=%b res=%b want 1 0 %b", i, rv, ill, res, ea[i]);
      end
    end
    @(negedge clock);
    cmp++;
    if ({go5, mc5, turn5} !== {1'b1, 7'd4, 2'b10}) begin
      errs++;
      $display("FAIL n5_row_over: got go=%b mc=%0d turn=%b want 1 4 10", go5, mc5, turn5);
    end
    pulse_ng(1);
    for (int i = 0; i < 3; i++) begin
      do_move(1, pb[i], 2'b01, rv, ill, res);
      cmp++;
      if ({rv, ill, res} !== {1'b1, 1'b0, 2'b00}) begin
        errs++;
        $display("FAIL n5_wrap move%0d: got rv=%b ill=%b res=%b want 1 0 00", i, rv, ill, res);
      end
    end
    @(negedge clock);
    cmp++;
    if ({go5, mc5, turn5} !== {1'b0, 7'd3, 2'b10}) begin
      errs++;
      $display("FAIL n5_wrap_state: got go=%b mc=%0d turn=%b want 0 3 10", go5, mc5, turn5);
    end
  endtask

  task automatic test_new_game_scan;
    int seen;
    pulse_ng(0);
    set_in(0, 1'b1, 1, 2'b01);
    @(posedge clock);           // accepted -> WRITE
    @(negedge clock);
    set_in(0, 1'b0, 0, 2'b00);
    @(negedge clock);           // now in SCAN
    rda3 = 7'd1;
    #1;
    cmp++;
    if ({rdd3, mc3, rv3, mi3.move_ready} !== {2'b01, 7'd1, 1'b0, 1'b0}) begin
      errs++;
      $display("FAIL ng_pre: got cell1=%b mc=%0d rv=%b rdy=%b want 01 1 0 0", rdd3, mc3, rv3, mi3.move_ready);
    end
    pulse_ng(0);
    #1;
    cmp++;
    if ({rdd3, mc3, turn3, mi3.move_ready, rv3} !== {2'b00, 7'd0, 2'b01, 1'b1, 1'b0}) begin
      errs++;
      $display("FAIL ng_post: got cell1=%b mc=%0d turn=%b rdy=%b rv=%b want 00 0 01 1 0",
               rdd3, mc3, turn3, mi3.move_ready, rv3);
    end
    seen = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clock);
      if (rv3) seen++;
    end
    cmp++;
    if (seen !== 0) begin
      errs++;
      $display("FAIL ng_no_result: got %0d result_valid cycles want 0", seen);
    end
  endtask

  task automatic test_async_reset;
    logic rv, ill; logic [1:0] res;
    pulse_ng(0);
    do_move(0, 1, 2'b01, rv, ill, res);
    @(negedge clock);
    set_in(0, 1'b1, 9, 2'b10);
    rda3 = 7'd1;
    @(posedge clock);           // accepted -> WRITE
    #2;
    resetn = 1'b0;
    #1;
    cmp++;
    if ({mc3, turn3, rdd3, mi3.move_ready, rv3, go3} !== {7'd0, 2'b01, 2'b00, 1'b1, 1'b0, 1'b0}) begin
      errs++;
      $display("FAIL async_reset: got mc=%0d turn=%b cell1=%b rdy=%b rv=%b go=%b want 0 01 00 1 0 0",
               mc3, turn3, rdd3, mi3.move_ready, rv3, go3);
    end
    rda3 = 7'd9;
    #1;
    cmp++;
    if (rdd3 !== 2'b00) begin
      errs++;
      $display("FAIL async_target: got %b want 00", rdd3);
    end
    set_in(0, 1'b0, 0, 2'b00);
    @(negedge clock);
    resetn = 1'b1;
    @(negedge clock);
  endtask

  initial begin
    test_reset();
    test_p2_loss();
    test_tie();
    test_illegal();
    test_n5_row();
    test_new_game_scan();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, errs);
    $finish;
  end
endmodule
